// File: rtl/z80_seq_pkg.sv
// Shared definitions for the Z80 stack sequencers (RET cc, PUSH, CALL).
// Holds the sequencer state encoding, M-cycle indices and T-counter width.
package z80_seq_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    M1X   = 3'd1,
    RD_LO = 3'd2,
    RD_HI = 3'd3,
    DONE  = 3'd4
  } seq_state_e;

  localparam int TCNT_W = 3;

  localparam logic [1:0] MCYC_M1X   = 2'd0;
  localparam logic [1:0] MCYC_RD_LO = 2'd1;
  localparam logic [1:0] MCYC_RD_HI = 2'd2;

  // T2 is the only T-state in which WAIT is honoured
  localparam logic [TCNT_W-1:0] TCNT_T2 = 3'd2;

endpackage

// File: rtl/z80_tstate_counter.sv
// T-state counter shared by the stack sequencers.
// load wins over counting; counting stalls while hold is high (wait states).
// tc flags that the count equals the caller-supplied terminal value.
module z80_tstate_counter
  import z80_seq_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [TCNT_W-1:0] load_val,
  input  logic              en,
  input  logic              hold,
  input  logic [TCNT_W-1:0] term_val,
  output logic [TCNT_W-1:0] count,
  output logic              tc
);

  // T-state count register: load, advance, or stall in a wait state
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of block evaluation order.
    if (reset)
      count <= '0;
    else if (load)
      count <= load_val;
    else if (en && !hold)
      count <= count + 1'b1;
  end

  assign tc = (count == term_val);

endmodule

// File: rtl/z80_cond_pop_seq.sv
// RET cc stack-pop sequencer: optional M1 extension for condition
// evaluation, then zero or two memory-read M-cycles, then a done pulse
// carrying the new PC/SP. Tie cond_met high for RET/RETI/RETN.
// Optional Z80FI_TRACE_EN adds registered formal-trace outputs.
module z80_cond_pop_seq
  import z80_seq_pkg::*;
#(
  parameter int RD_TCYCLES = 3,
  parameter int M1_EXTRA_T = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        cond_met,
  input  logic [15:0] sp_in,
  input  logic [15:0] ip_in,
  input  logic        mem_wait,
  input  logic [7:0]  mem_rdata,
  output logic        mem_rd,
  output logic [15:0] mem_addr,
  output logic        busy,
  output logic        done,
  output logic        taken,
  output logic [15:0] ip_out,
  output logic [15:0] sp_out,
  output logic [1:0]  mcycle
`ifdef Z80FI_TRACE_EN
  ,
  output logic [3:0]  trace_mcycle_type2,
  output logic [3:0]  trace_mcycle_type3,
  output logic [15:0] trace_raddr,
  output logic [15:0] trace_raddr2,
  output logic [7:0]  trace_rdata,
  output logic [7:0]  trace_rdata2,
  output logic [3:0]  trace_tcycles1
`endif
);

  localparam logic [TCNT_W-1:0] RD_LAST  = TCNT_W'(RD_TCYCLES);
  localparam logic [TCNT_W-1:0] M1X_LAST = (M1_EXTRA_T > 0) ? TCNT_W'(M1_EXTRA_T - 1) : '0;

  seq_state_e        state;
  logic [15:0]       sp_q;
  logic [15:0]       ip_q;
  logic              cond_q;
  logic [7:0]        lo_q;

  logic              cnt_load;
  logic [TCNT_W-1:0] cnt_load_val;
  logic              cnt_en;
  logic              cnt_hold;
  logic [TCNT_W-1:0] cnt_term;
  logic [TCNT_W-1:0] cnt;
  logic              cnt_tc;

  z80_tstate_counter u_tcnt (
    .clk      (clk),
    .reset    (reset),
    .load     (cnt_load),
    .load_val (cnt_load_val),
    .en       (cnt_en),
    .hold     (cnt_hold),
    .term_val (cnt_term),
    .count    (cnt),
    .tc       (cnt_tc)
  );

  // Counter control: M1X counts from 0, each read M-cycle counts from 1
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    cnt_load     = 1'b0;
    cnt_load_val = '0;
    cnt_en       = 1'b0;
    cnt_hold     = 1'b0;
    cnt_term     = RD_LAST;
    case (state)
      IDLE: begin
        if (start) begin
          cnt_load     = 1'b1;
          cnt_load_val = (M1_EXTRA_T > 0) ? TCNT_W'(0) : TCNT_W'(1);
        end
      end
      M1X: begin
        cnt_term = M1X_LAST;
        if (cnt_tc) begin
          cnt_load     = 1'b1;
          cnt_load_val = TCNT_W'(1);
        end else begin
          cnt_en = 1'b1;
        end
      end
      RD_LO, RD_HI: begin
        if (cnt_tc) begin
          cnt_load     = 1'b1;
          cnt_load_val = TCNT_W'(1);
        end else begin
          cnt_en   = 1'b1;
          cnt_hold = (cnt == TCNT_T2) && mem_wait;
        end
      end
      default: ;
    endcase
  end

  // Sequencer FSM with registered bus and result outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      sp_q     <= '0;
      ip_q     <= '0;
      cond_q   <= 1'b0;
      lo_q     <= '0;
      mem_rd   <= 1'b0;
      mem_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      taken    <= 1'b0;
      ip_out   <= '0;
      sp_out   <= '0;
      mcycle   <= MCYC_M1X;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            sp_q   <= sp_in;
            ip_q   <= ip_in;
            cond_q <= cond_met;
            if (M1_EXTRA_T > 0) begin
              state  <= M1X;
              busy   <= 1'b1;
              mcycle <= MCYC_M1X;
            end else if (cond_met) begin
              state    <= RD_LO;
              busy     <= 1'b1;
              mem_rd   <= 1'b1;
              mem_addr <= sp_in;
              mcycle   <= MCYC_RD_LO;
            end else begin
              state  <= DONE;
              done   <= 1'b1;
              taken  <= 1'b0;
              ip_out <= ip_in + 16'd1;
              sp_out <= sp_in;
            end
          end
        end
        M1X: begin
          if (cnt_tc) begin
            if (cond_q) begin
              state    <= RD_LO;
              mem_rd   <= 1'b1;
              mem_addr <= sp_q;
              mcycle   <= MCYC_RD_LO;
            end else begin
              state  <= DONE;
              busy   <= 1'b0;
              done   <= 1'b1;
              taken  <= 1'b0;
              ip_out <= ip_q + 16'd1;
              sp_out <= sp_q;
            end
          end
        end
        RD_LO: begin
          if (cnt_tc) begin
            state    <= RD_HI;
            lo_q     <= mem_rdata;
            mem_addr <= sp_q + 16'd1;
            mcycle   <= MCYC_RD_HI;
          end
        end
        RD_HI: begin
          if (cnt_tc) begin
            state  <= DONE;
            mem_rd <= 1'b0;
            mcycle <= MCYC_M1X;
            busy   <= 1'b0;
            done   <= 1'b1;
            taken  <= 1'b1;
            ip_out <= {mem_rdata, lo_q};
            sp_out <= sp_q + 16'd2;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef Z80FI_TRACE_EN
  localparam logic [3:0] CYCLE_NONE     = 4'd0;
  localparam logic [3:0] CYCLE_RDWR_MEM = 4'd1;

  logic enter_done;
  logic enter_taken;

  // Identify the cycle that moves the FSM into DONE, and whether it popped
  always_comb begin
    enter_taken = (state == RD_HI) && cnt_tc;
    enter_done  = enter_taken
               || ((state == M1X) && cnt_tc && !cond_q)
               || ((state == IDLE) && start && (M1_EXTRA_T == 0) && !cond_met);
  end

  // Trace record captured alongside the done pulse
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trace_mcycle_type2 <= '0;
      trace_mcycle_type3 <= '0;
      trace_raddr        <= '0;
      trace_raddr2       <= '0;
      trace_rdata        <= '0;
      trace_rdata2       <= '0;
      trace_tcycles1     <= '0;
    end else if (enter_done) begin
      trace_mcycle_type2 <= enter_taken ? CYCLE_RDWR_MEM : CYCLE_NONE;
      trace_mcycle_type3 <= CYCLE_RDWR_MEM;
      trace_raddr        <= sp_q;
      trace_raddr2       <= sp_q + 16'd1;
      trace_rdata        <= lo_q;
      trace_rdata2       <= mem_rdata;
      trace_tcycles1     <= 4'(4 + M1_EXTRA_T);
    end
  end
`endif

endmodule

// File: tb/tb_z80_cond_pop_seq.sv
// Self-checking bench for z80_cond_pop_seq with default parameters.
// Expected results and bus addresses are queued when a start is driven
// and compared when the DUT reads memory or pulses done.
module tb_z80_cond_pop_seq;

  localparam int RD_T  = 3;
  localparam int M1X_T = 1;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cond_met;
  logic [15:0] sp_in;
  logic [15:0] ip_in;
  logic        mem_wait;
  logic [7:0]  mem_rdata;
  logic        mem_rd;
  logic [15:0] mem_addr;
  logic        busy;
  logic        done;
  logic        taken;
  logic [15:0] ip_out;
  logic [15:0] sp_out;
  logic [1:0]  mcycle;

  logic [7:0] mem [0:65535];
  assign mem_rdata = mem[mem_addr];

  typedef struct {
    logic        taken;
    logic [15:0] ip;
    logic [15:0] sp;
    int          lat;
    int          start_cyc;
  } exp_t;

  exp_t        exp_q[$];
  logic [17:0] addr_q[$];
  exp_t        e;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int rd_k    = 0;
  int wl      = 0;
  int wh      = 0;

  z80_cond_pop_seq #(.RD_TCYCLES(RD_T), .M1_EXTRA_T(M1X_T)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cond_met  (cond_met),
    .sp_in     (sp_in),
    .ip_in     (ip_in),
    .mem_wait  (mem_wait),
    .mem_rdata (mem_rdata),
    .mem_rd    (mem_rd),
    .mem_addr  (mem_addr),
    .busy      (busy),
    .done      (done),
    .taken     (taken),
    .ip_out    (ip_out),
    .sp_out    (sp_out),
    .mcycle    (mcycle)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Bus responder and scoreboard, sampled mid-cycle
  always @(negedge clk) begin
    if (reset) begin
      rd_k     = 0;
      mem_wait = 1'b0;
    end else begin
      if (mem_rd) begin
        if (addr_q.size() == 0) check("rd_unexpected", {31'b0, mem_rd}, 32'd0);
        else                    check("rd_mcyc_addr", {mcycle, mem_addr}, addr_q.pop_front());
        mem_wait = (rd_k >= 1 && rd_k <= wl) ||
                   (rd_k >= RD_T + wl + 1 && rd_k <= RD_T + wl + wh);
        rd_k++;
      end else begin
        rd_k     = 0;
        mem_wait = 1'b0;
      end
      if (done) begin
        if (exp_q.size() == 0) begin
          check("done_unexpected", {31'b0, done}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("taken",   taken, e.taken);
          check("ip_out",  ip_out, e.ip);
          check("sp_out",  sp_out, e.sp);
          check("latency", cyc - e.start_cyc, e.lat);
          check("busy_at_done", busy, 0);
        end
      end
    end
  end

  // Queue the expectations for one accepted start and raise the start pulse
  task automatic issue(input logic tk, input logic [15:0] sp, input logic [15:0] ip,
                       input logic [7:0] lo, input logic [7:0] hi, input int w_lo, input int w_hi);
    logic [15:0] sp1;
    exp_t x;
    sp1 = sp + 16'd1;
    mem[sp]  = lo;
    mem[sp1] = hi;
    wl = w_lo;
    wh = w_hi;
    x.taken     = tk;
    x.ip        = tk ? {hi, lo} : ip + 16'd1;
    x.sp        = tk ? sp + 16'd2 : sp;
    x.lat       = tk ? (M1X_T + 2 * RD_T + w_lo + w_hi + 1) : (M1X_T + 1);
    x.start_cyc = cyc;
    exp_q.push_back(x);
    if (tk) begin
      for (int i = 0; i < RD_T + w_lo; i++) addr_q.push_back({2'd1, sp});
      for (int i = 0; i < RD_T + w_hi; i++) addr_q.push_back({2'd2, sp1});
    end
    start    = 1'b1;
    cond_met = tk;
    sp_in    = sp;
    ip_in    = ip;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 200; i++) begin
      if (exp_q.size() == 0) break;
      @(negedge clk); #1;
    end
    check("done_timeout", exp_q.size(), 0);
    check("addr_leftover", addr_q.size(), 0);
  endtask

  task automatic run(input logic tk, input logic [15:0] sp, input logic [15:0] ip,
                     input logic [7:0] lo, input logic [7:0] hi, input int w_lo, input int w_hi);
    logic [15:0] eip;
    logic [15:0] esp;
    eip = tk ? {hi, lo} : ip + 16'd1;
    esp = tk ? sp + 16'd2 : sp;
    @(negedge clk); #1;
    issue(tk, sp, ip, lo, hi, w_lo, w_hi);
    @(negedge clk); #1;
    start    = 1'b0;
    cond_met = $urandom_range(0, 1);
    sp_in    = 16'($urandom);
    ip_in    = 16'($urandom);
    wait_idle();
    repeat (2) @(negedge clk);
    #1;
    check("taken_hold", taken, tk);
    check("ip_hold", ip_out, eip);
    check("sp_hold", sp_out, esp);
  endtask

  initial begin
    int k;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    reset    = 1'b1;
    start    = 1'b0;
    cond_met = 1'b0;
    sp_in    = '0;
    ip_in    = '0;
    mem_wait = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    check("rst_mem_rd", mem_rd, 0);
    check("rst_addr",   mem_addr, 0);
    check("rst_busy",   busy, 0);
    check("rst_done",   done, 0);
    check("rst_taken",  taken, 0);
    check("rst_ip",     ip_out, 0);
    check("rst_sp",     sp_out, 0);
    check("rst_mcycle", mcycle, 0);
    reset = 1'b0;

    // Basic not-taken and taken pops, wrap, and WAIT in T2 of the low read
    run(1'b0, 16'h1234, 16'h0100, 8'h00, 8'h00, 0, 0);
    run(1'b1, 16'h8000, 16'h0100, 8'h34, 8'h12, 0, 0);
    run(1'b1, 16'hFFFF, 16'h0200, 8'hCD, 8'hAB, 0, 0);
    run(1'b1, 16'h8000, 16'h0300, 8'h34, 8'h12, 2, 0);
    run(1'b0, 16'h0055, 16'hFFFF, 8'h00, 8'h00, 0, 0);
    run(1'b1, 16'h4000, 16'h0400, 8'h78, 8'h56, 1, 3);

    // Reset at T-state 2 of the high read aborts without a done pulse
    @(negedge clk); #1;
    issue(1'b1, 16'h8000, 16'h0500, 8'h11, 8'h22, 0, 0);
    @(negedge clk); #1;
    start = 1'b0;
    k = 0;
    for (int i = 0; i < 50; i++) begin
      if (mem_rd && mem_addr == 16'h8001) k++;
      if (k == 2) break;
      @(negedge clk); #1;
    end
    check("rst_reach_rdhi", k, 2);
    reset = 1'b1;
    #1;
    check("abort_mem_rd", mem_rd, 0);
    check("abort_busy",   busy, 0);
    check("abort_done",   done, 0);
    check("abort_taken",  taken, 0);
    check("abort_ip",     ip_out, 0);
    check("abort_sp",     sp_out, 0);
    check("abort_mcycle", mcycle, 0);
    exp_q.delete();
    addr_q.delete();
    wl = 0;
    wh = 0;
    repeat (2) @(negedge clk);
    #1;
    reset = 1'b0;
    run(1'b0, 16'h2000, 16'h0600, 8'h00, 8'h00, 0, 0);

    // Starts while busy and in the DONE cycle are ignored
    @(negedge clk); #1;
    issue(1'b1, 16'h3000, 16'h0700, 8'h9A, 8'hBC, 0, 0);
    @(negedge clk); #1;
    start = 1'b0;
    @(negedge clk); #1;
    check("busy_mid", busy, 1);
    start    = 1'b1;
    cond_met = 1'b1;
    sp_in    = 16'h4444;
    @(negedge clk); #1;
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) break;
      @(negedge clk); #1;
    end
    check("done_seen", done, 1);
    start    = 1'b1;
    cond_met = 1'b0;
    ip_in    = 16'h5555;
    @(negedge clk); #1;
    start = 1'b0;
    repeat (12) @(negedge clk);
    #1;
    check("ignored_busy", busy, 0);
    check("ignored_ip", ip_out, 16'hBC9A);
    check("ignored_leftover", exp_q.size(), 0);

    // A few random pops with random waits
    for (int n = 0; n < 5; n++) begin
      run(1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom),
          8'($urandom), 8'($urandom), $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

endmodule

// File: doc/z80_cond_pop_seq.md
Name: z80_cond_pop_seq

Overview:
- Sequencer for the stack-pop M-cycles of RET cc (also reusable for unconditional RET/RETI/RETN with cond_met tied high).
- Started by the decoder after M1 T4. Adds the fifth M1 T-state used for condition evaluation, then runs either zero or two memory-read M-cycles.
- Returns the new PC and SP to the register file.
- Sits between the instruction decoder and the bus interface unit. One T-state equals one clk cycle.

Parameters:
- RD_TCYCLES, 3: minimum T-states per memory-read M-cycle, excluding wait states; legal 3..7.
- M1_EXTRA_T, 1: extra T-states appended to M1 before the condition is resolved; legal 0..3.

Ports:
- clk  in  1  system clock, one T-state per cycle
- reset  in  1  asynchronous, active-high reset
- start  in  1  one-cycle pulse from the decoder in the cycle after M1 T4; ignored while busy
- cond_met  in  1  condition result; sampled in the cycle start is accepted
- sp_in  in  16  stack pointer; sampled with start
- ip_in  in  16  address of the RET cc opcode; sampled with start
- mem_wait  in  1  WAIT from the bus; sampled in T2 of each read M-cycle
- mem_rdata  in  8  read data; captured in the last T-state of each read M-cycle
- mem_rd  out  1  memory-read strobe, high for the full read M-cycle
- mem_addr  out  16  read address; valid while mem_rd is high
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle completion pulse
- taken  out  1  valid with done: 1 if the pop occurred
- ip_out  out  16  valid with done: {hi,lo} if taken, else ip_in+1
- sp_out  out  16  valid with done: sp_in+2 if taken, else sp_in
- mcycle  out  2  current M-cycle index: 0 = M1 extension, 1 = read low, 2 = read high

Behaviour:
- Reset value of every output is 0. Reset asserted mid-operation aborts immediately: state returns to IDLE, mem_rd drops asynchronously, and no done pulse is issued.
- States: IDLE, M1X, RD_LO, RD_HI, DONE.
- IDLE:
  - start high: latch sp_in, ip_in and cond_met.
  - If M1_EXTRA_T > 0, go to M1X with the T-counter at 0.
  - If M1_EXTRA_T = 0, go straight to RD_LO (taken) or DONE (not taken).
- M1X:
  - Lasts M1_EXTRA_T cycles, then goes to RD_LO if cond_met was latched high, else to DONE.
- RD_LO:
  - mem_rd=1, mem_addr=sp, mcycle=1.
  - The T-counter runs 1..RD_TCYCLES.
  - While the counter is 2 and mem_wait=1, the counter holds (Tw states, unbounded).
  - At counter RD_TCYCLES, lo<=mem_rdata and go to RD_HI.
- RD_HI:
  - Same as RD_LO with mem_addr=sp+1 (16-bit wrap), mcycle=2.
  - At the last T-state, hi<=mem_rdata and go to DONE.
- DONE:
  - done=1 for one cycle; taken, ip_out and sp_out are driven; busy=0.
  - Next state is IDLE.
  - start is accepted in IDLE only; a start coincident with DONE is ignored.
- Arithmetic: all address arithmetic is 16-bit modulo 2^16.
  - sp=FFFF reads FFFF then 0000 and returns sp_out=0001.
  - ip_in=FFFF not taken returns 0000.
- Latency, start to done pulse:
  - Not taken: M1_EXTRA_T+1 cycles.
  - Taken: M1_EXTRA_T + 2*RD_TCYCLES + waits + 1 cycles.
- mem_rd never asserts for a not-taken condition.
- ip_out, sp_out and taken hold their values after done until the next start.

Optional Feature:
- Macro: Z80FI_TRACE_EN.
- Defined: adds outputs for formal cross-checking against the instruction specs:
  - trace_mcycle_type2/3 (CYCLE_* encoding from z80fi.vh): type2 = RDWR_MEM if taken else NONE; type3 = RDWR_MEM.
  - trace_raddr, trace_raddr2, trace_rdata, trace_rdata2, trace_tcycles1 (4+M1_EXTRA_T).
  - All trace outputs are registered at DONE and cleared by reset.
- Undefined: these ports and their registers are absent; core behaviour is unchanged.

Decomposition:
- The shared package z80_seq_pkg holds:
  - the state enum (IDLE, M1X, RD_LO, RD_HI, DONE);
  - the mcycle index constants;
  - the T-counter width constant (3 bits).
- CYCLE_* encodings come from the existing z80fi.vh.
- Sub-module z80_tstate_counter: load, count-enable, wait-hold and terminal-count output. It is reused later by the PUSH/CALL sequencers.

Test Plan:
- Not taken, defaults: sp_in=1234, ip_in=0100, cond_met=0, start -> done 2 cycles later, taken=0, ip_out=0101, sp_out=1234, mem_rd never high.
- Taken, defaults: sp_in=8000, mem[8000]=34, mem[8001]=12 -> mem_rd 6 cycles (addr 8000 x3, then 8001 x3), done 8 cycles after start, ip_out=1234, sp_out=8002.
- Wrap: sp_in=FFFF, mem[FFFF]=CD, mem[0000]=AB, taken -> mem_addr FFFF then 0000, ip_out=ABCD, sp_out=0001.
- Wait states: as the taken case, mem_wait=1 for 2 cycles in T2 of RD_LO -> RD_LO lasts 5 cycles, done 10 cycles after start, data still 1234.
- Reset in RD_HI: assert reset at counter 2 -> all outputs 0 immediately, no done. The next start (sp=2000, not taken) completes normally in 2 cycles.
- start pulsed while busy and coincident with DONE -> ignored; exactly one done per accepted start.
